// File: rtl/seg_count_monitor.sv
// -----------------------------------------------------------------------------
// seg_count_monitor
//
// Watches one road's two-digit seven-segment countdown display and recovers the
// binary value shown. Each msb/lsb pair must be seen for STABLE_CYCLES
// consecutive samples before it is accepted, so short segment glitches never
// reach the outputs. Accepted values are checked against the countdown rules:
// a step down by one, a reload upward, or a repeat after an invalid glyph are
// legal. A drop of more than one flags a sequence fault. Invalid glyphs and
// sequence faults are both counted in a saturating counter.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   seg_msb      tens-digit pattern {g,f,e,d,c,b,a}, active-low
//   seg_lsb      units-digit pattern, same encoding
//   count_out    last accepted valid value, binary 0..99
//   count_valid  high once any valid value has been accepted
//   reload       one-cycle pulse: accepted value above the previous value
//   glyph_err    one-cycle pulse: accepted pair contains a non-digit pattern
//   seq_err      one-cycle pulse: accepted value below previous value minus 1
//   err_count    saturating count of glyph_err and seq_err events
// -----------------------------------------------------------------------------
module seg_count_monitor #(
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned ERR_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           seg_msb,
   input  logic [6:0]           seg_lsb,
   output logic [7:0]           count_out,
   output logic                 count_valid,
   output logic                 reload,
   output logic                 glyph_err,
   output logic                 seq_err,
   output logic [ERR_WIDTH-1:0] err_count
);

   localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

   typedef enum logic [0:0] {
      StWaitFirst,
      StTrack
   } state_e;

   // Returns {valid, digit}; anything that is not one of the ten digit
   // glyphs (blank included) decodes as invalid.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] dec;
      case (seg)
         7'h40:   dec = 5'h10;
         7'h79:   dec = 5'h11;
         7'h24:   dec = 5'h12;
         7'h30:   dec = 5'h13;
         7'h19:   dec = 5'h14;
         7'h12:   dec = 5'h15;
         7'h02:   dec = 5'h16;
         7'h78:   dec = 5'h17;
         7'h00:   dec = 5'h18;
         7'h10:   dec = 5'h19;
         default: dec = 5'h00;
      endcase
      return dec;
   endfunction

   // Input sample and glitch filter
   logic [13:0]          sample_q, sample_d;
   logic [CntW-1:0]      stab_cnt_q, stab_cnt_d;
   logic [13:0]          last_stable_q, last_stable_d;
   logic                 have_stable_q, have_stable_d;

   // Tracking state and registered outputs
   state_e               state_q, state_d;
   logic [7:0]           count_q, count_d;
   logic                 reload_q, reload_d;
   logic                 glyph_q, glyph_d;
   logic                 seq_q, seq_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;

   logic                 accept;
   logic [4:0]           msb_dec, lsb_dec;
   logic                 pair_ok;
   logic [7:0]           tens, units, value;

   // Stability counter: length of the run of identical samples, saturating.
   // A zero count (only right after reset) always starts a fresh run so the
   // first pair after reset needs the full number of samples.
   always_comb begin
      sample_d = {seg_msb, seg_lsb};
      if ((stab_cnt_q != '0) && (sample_d == sample_q)) begin
         stab_cnt_d = (stab_cnt_q == CntMax) ? stab_cnt_q : stab_cnt_q + CntW'(1);
      end else begin
         stab_cnt_d = CntW'(1);
      end
   end

   // A steady pair is taken once: last_stable blocks re-acceptance while held,
   // and also hides a short glitch that returns to the same pair.
   assign accept = (stab_cnt_q == CntMax) && (!have_stable_q || (sample_q != last_stable_q));

   assign msb_dec = decode_glyph(sample_q[13:7]);
   assign lsb_dec = decode_glyph(sample_q[6:0]);
   assign pair_ok = msb_dec[4] & lsb_dec[4];
   assign tens    = {4'h0, msb_dec[3:0]};
   assign units   = {4'h0, lsb_dec[3:0]};
   assign value   = tens * 8'd10 + units;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      reload_d      = 1'b0;
      glyph_d       = 1'b0;
      seq_d         = 1'b0;
      last_stable_d = last_stable_q;
      have_stable_d = have_stable_q;

      if (accept) begin
         last_stable_d = sample_q;
         have_stable_d = 1'b1;
         if (!pair_ok) begin
            // count_out is held so the next valid value is judged against it
            glyph_d = 1'b1;
         end else begin
            count_d = value;
            case (state_q)
               StWaitFirst: begin
                  state_d = StTrack;
               end
               StTrack: begin
                  if (value > count_q) begin
                     reload_d = 1'b1;
                  end else if ((count_q != 8'd0) && (value < count_q - 8'd1)) begin
                     // p-1 only exists for p > 0; at zero nothing can drop
                     seq_d = 1'b1;
                  end
               end
               default: state_d = StWaitFirst;
            endcase
         end
      end

      err_d = err_q;
      if ((glyph_d || seq_d) && (err_q != {ERR_WIDTH{1'b1}})) begin
         err_d = err_q + ERR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q      <= '0;
         stab_cnt_q    <= '0;
         last_stable_q <= '0;
         have_stable_q <= 1'b0;
         state_q       <= StWaitFirst;
         count_q       <= '0;
         reload_q      <= 1'b0;
         glyph_q       <= 1'b0;
         seq_q         <= 1'b0;
         err_q         <= '0;
      end else begin
         sample_q      <= sample_d;
         stab_cnt_q    <= stab_cnt_d;
         last_stable_q <= last_stable_d;
         have_stable_q <= have_stable_d;
         state_q       <= state_d;
         count_q       <= count_d;
         reload_q      <= reload_d;
         glyph_q       <= glyph_d;
         seq_q         <= seq_d;
         err_q         <= err_d;
      end
   end

   assign count_out   = count_q;
   assign count_valid = (state_q == StTrack);
   assign reload      = reload_q;
   assign glyph_err   = glyph_q;
   assign seq_err     = seq_q;
   assign err_count   = err_q;

   // The two error pulses come from disjoint branches and share the counter
   // increment, so they must never coincide.
   a_err_exclusive : assert property (@(posedge clk) disable iff (reset)
      !(glyph_err && seq_err));

endmodule

// File: tb/tb_seg_count_monitor.sv
module tb_seg_count_monitor;

   localparam int unsigned S  = 2;
   localparam int unsigned EW = 8;
   localparam int          ERR_MAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [6:0]    seg_msb = 7'h7F;
   logic [6:0]    seg_lsb = 7'h7F;
   logic [7:0]    count_out;
   logic          count_valid;
   logic          reload;
   logic          glyph_err;
   logic          seq_err;
   logic [EW-1:0] err_count;

   int checks = 0;
   int failures = 0;

   seg_count_monitor #(
      .STABLE_CYCLES(S),
      .ERR_WIDTH    (EW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_msb    (seg_msb),
      .seg_lsb    (seg_lsb),
      .count_out  (count_out),
      .count_valid(count_valid),
      .reload     (reload),
      .glyph_err  (glyph_err),
      .seq_err    (seq_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Reference model: a window of the last S presented pairs, plus the
   // display-level facts (last taken pair, shown value, error total).
   logic [13:0] hist[$];
   bit          m_valid, m_has, m_reload, m_glyph, m_seq;
   int          m_count, m_err;
   logic [13:0] m_last;

   logic [19:0] act;
   assign act = {count_valid, count_out, reload, glyph_err, seq_err, err_count};

   function automatic int digit_of(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (glyph[i] == s) return i;
      return -1;
   endfunction

   function automatic logic [19:0] exp_vec();
      return {m_valid, 8'(m_count), m_reload, m_glyph, m_seq, EW'(m_err)};
   endfunction

   task automatic model_reset();
      hist.delete();
      m_valid = 0; m_has = 0; m_reload = 0; m_glyph = 0; m_seq = 0;
      m_count = 0; m_err = 0; m_last = '0;
   endtask

   // One clock edge with pair p sampled at it; outputs reflect the window
   // of pairs sampled at the previous S edges.
   task automatic model_edge(input logic [13:0] p);
      bit same;
      int d1, d0, v;
      m_reload = 0; m_glyph = 0; m_seq = 0;
      if (hist.size() == S) begin
         same = 1;
         foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
         if (same && (!m_has || hist[0] != m_last)) begin
            m_has = 1;
            m_last = hist[0];
            d1 = digit_of(hist[0][13:7]);
            d0 = digit_of(hist[0][6:0]);
            if (d1 < 0 || d0 < 0) begin
               m_glyph = 1;
            end else begin
               v = d1 * 10 + d0;
               if (m_valid) begin
                  if (v > m_count) m_reload = 1;
                  else if (v < m_count - 1) m_seq = 1;
               end
               m_valid = 1;
               m_count = v;
            end
            if ((m_glyph || m_seq) && m_err < ERR_MAX) m_err++;
         end
      end
      hist.push_back(p);
      if (hist.size() > S) void'(hist.pop_front());
   endtask

   task automatic cycle(input logic [6:0] m, input logic [6:0] l);
      @(negedge clk);
      seg_msb = m;
      seg_lsb = l;
      @(posedge clk);
      model_edge({m, l});
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (act !== 20'h0) begin
         failures++;
         $display("FAIL reset_state: got %h want %h", act, 20'h0);
      end
      release_reset();
   endtask

   task automatic test_first_value();
      for (int i = 0; i < 4; i++) begin
         cycle(glyph[2], glyph[5]);
         checks++;
         if (act !== exp_vec()) begin
            failures++;
            $display("FAIL first_track: cyc %0d got %h want %h", i, act, exp_vec());
         end
         if (i == 1) begin
            checks++;
            if (count_valid !== 1'b0) begin
               failures++;
               $display("FAIL first_early: count_valid=%b want 0", count_valid);
            end
         end
         if (i == 2) begin
            checks++;
            if (count_valid !== 1'b1 || count_out !== 8'd25 || err_count !== 0) begin
               failures++;
               $display("FAIL first_latency: valid=%b count=%0d err=%0d want 1 25 0",
                        count_valid, count_out, err_count);
            end
         end
      end
   endtask

   task automatic test_countdown();
      int pulses;
      for (int v = 24; v >= 22; v--) begin
         pulses = 0;
         for (int i = 0; i < 5; i++) begin
            cycle(glyph[v / 10], glyph[v % 10]);
            pulses += int'(reload) + int'(seq_err) + int'(glyph_err);
            checks++;
            if (act !== exp_vec()) begin
               failures++;
               $display("FAIL countdown_track: v=%0d got %h want %h", v, act, exp_vec());
            end
         end
         checks++;
         if (count_out !== 8'(v) || pulses != 0) begin
            failures++;
            $display("FAIL countdown_step: count=%0d pulses=%0d want %0d 0", count_out, pulses, v);
         end
      end
   endtask

   task automatic test_seq_err();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(glyph[1], glyph[9]);
         pulses += int'(seq_err);
         checks++;
         if (act !== exp_vec()) begin
            failures++;
            $display("FAIL seq_track: got %h want %h", act, exp_vec());
         end
      end
      checks++;
      if (count_out !== 8'd19 || pulses != 1 || err_count !== 8'd1) begin
         failures++;
         $display("FAIL seq_err: count=%0d pulses=%0d err=%0d want 19 1 1",
                  count_out, pulses, err_count);
      end
   endtask

   task automatic test_glyph_glitch();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(glyph[1], 7'h7F);
         pulses += int'(glyph_err);
      end
      cycle(glyph[1], 7'h7F);
      pulses += int'(glyph_err);
      checks++;
      if (count_out !== 8'd19 || pulses != 1 || err_count !== 8'd2 || act !== exp_vec()) begin
         failures++;
         $display("FAIL glyph_err: count=%0d pulses=%0d err=%0d want 19 1 2",
                  count_out, pulses, err_count);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(glyph[1], glyph[8]);
         pulses += int'(reload) + int'(seq_err) + int'(glyph_err);
      end
      checks++;
      if (count_out !== 8'd18 || pulses != 0 || act !== exp_vec()) begin
         failures++;
         $display("FAIL after_glyph: count=%0d pulses=%0d want 18 0", count_out, pulses);
      end
      cycle(glyph[1], glyph[0]);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(glyph[1], glyph[8]);
         pulses += int'(reload) + int'(seq_err) + int'(glyph_err);
         checks++;
         if (act !== exp_vec()) begin
            failures++;
            $display("FAIL glitch_track: got %h want %h", act, exp_vec());
         end
      end
      checks++;
      if (count_out !== 8'd18 || pulses != 0 || err_count !== 8'd2) begin
         failures++;
         $display("FAIL glitch: count=%0d pulses=%0d err=%0d want 18 0 2",
                  count_out, pulses, err_count);
      end
   endtask

   task automatic test_reload();
      int pulses;
      for (int i = 0; i < 4; i++) cycle(glyph[0], glyph[0]);
      checks++;
      if (count_out !== 8'd0 || act !== exp_vec()) begin
         failures++;
         $display("FAIL to_zero: count=%0d want 0", count_out);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(glyph[3], glyph[0]);
         pulses += int'(reload);
         checks++;
         if (act !== exp_vec()) begin
            failures++;
            $display("FAIL reload_track: got %h want %h", act, exp_vec());
         end
      end
      checks++;
      if (count_out !== 8'd30 || pulses != 1) begin
         failures++;
         $display("FAIL reload: count=%0d pulse_cycles=%0d want 30 1", count_out, pulses);
      end
   endtask

   task automatic test_random();
      logic [6:0] m, l;
      int kind, v, len;
      for (int seg = 0; seg < 150; seg++) begin
         kind = $urandom_range(0, 9);
         len = $urandom_range(1, 4);
         v = $urandom_range(0, 99);
         if (kind < 6 && m_valid) v = (m_count > 0) ? m_count - 1 : 99;
         m = glyph[v / 10];
         l = glyph[v % 10];
         if (kind == 8) l = 7'($urandom);
         if (kind == 9) begin
            m = 7'($urandom);
            len = 1;
         end
         for (int i = 0; i < len; i++) begin
            cycle(m, l);
            checks++;
            if (act !== exp_vec()) begin
               failures++;
               $display("FAIL random: seg %0d got %h want %h", seg, act, exp_vec());
            end
         end
      end
   endtask

   task automatic test_saturation_and_async_reset();
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(glyph[0], 7'h7F);
            else cycle(glyph[0], glyph[5]);
            checks++;
            if (act !== exp_vec()) begin
               failures++;
               $display("FAIL sat_track: n=%0d got %h want %h", n, act, exp_vec());
            end
         end
      end
      checks++;
      if (err_count !== 8'hFF) begin
         failures++;
         $display("FAIL saturate: err=%0d want 255", err_count);
      end
      cycle(glyph[0], 7'h7F);
      reset = 1'b1;
      #1;
      checks++;
      if (act !== 20'h0) begin
         failures++;
         $display("FAIL async_reset: got %h want %h", act, 20'h0);
      end
      release_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(glyph[4], glyph[2]);
         checks++;
         if (act !== exp_vec() || (i == 1 && count_valid !== 1'b0)) begin
            failures++;
            $display("FAIL post_reset: cyc %0d got %h want %h", i, act, exp_vec());
         end
      end
      checks++;
      if (count_out !== 8'd42 || count_valid !== 1'b1 || err_count !== 0) begin
         failures++;
         $display("FAIL post_reset_value: count=%0d valid=%b err=%0d want 42 1 0",
                  count_out, count_valid, err_count);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_value();
      test_countdown();
      test_seq_err();
      test_glyph_glitch();
      test_reload();
      test_random();
      test_saturation_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
